// File: rtl/mux_n_rr_pkg.sv
// mux_n_rr_pkg: shared constants and helpers for the round-robin N:1 mux.
//   DEF_BUS_WIDTH / DEF_NUM_IN : default parameter values
//   clog2(n)                   : ceil(log2(n)), 0 for n <= 1
//   sel_w(n)                   : select width, never below 1 bit
package mux_n_rr_pkg;

  localparam int DEF_BUS_WIDTH = 16;
  localparam int DEF_NUM_IN    = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_rr_rr_arbiter.sv
// rr_arbiter: round-robin grant over NUM_IN requesters.
// Holds the rotating priority pointer and, when MUX_N_RR_LAST_EN is
// defined, the packet lock that pins the grant to one channel until its
// last word is taken.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_req       : per-channel request (in_valid)
//   i_load_en   : downstream can take a word this cycle
//   i_last      : per-channel end-of-packet (MUX_N_RR_LAST_EN only)
//   o_grant     : one-hot grant, already qualified by i_load_en
//   o_idx       : index of the granted channel
module rr_arbiter
  import mux_n_rr_pkg::*;
#(
  parameter  int NUM_IN    = DEF_NUM_IN,
  localparam int SEL_WIDTH = sel_w(NUM_IN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IN-1:0]    i_req,
  input  logic                 i_load_en,
`ifdef MUX_N_RR_LAST_EN
  input  logic [NUM_IN-1:0]    i_last,
`endif
  output logic [NUM_IN-1:0]    o_grant,
  output logic [SEL_WIDTH-1:0] o_idx
);

  logic [SEL_WIDTH-1:0] r_ptr;
  logic [SEL_WIDTH-1:0] w_idx;
  logic [SEL_WIDTH-1:0] w_nxt;
  logic                 w_found;
  logic                 w_take;

`ifdef MUX_N_RR_LAST_EN
  logic                 r_lock;
  logic [SEL_WIDTH-1:0] r_lock_idx;
`endif

  // Wrap-around priority search starting at r_ptr; first hit wins.
  always_comb begin
    int                   c;
    logic [SEL_WIDTH-1:0] w_c;
    c       = 0;
    w_c     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 0; off < NUM_IN; off++) begin
      c = int'(r_ptr) + off;
      if (c >= NUM_IN) c = c - NUM_IN;
      w_c = c[SEL_WIDTH-1:0];
      if (!w_found && i_req[w_c]) begin
        w_found = 1'b1;
        w_idx   = w_c;
      end
    end
`ifdef MUX_N_RR_LAST_EN
    // Mid-packet only the locked channel may be served, even if idle.
    if (r_lock) begin
      w_found = i_req[r_lock_idx];
      w_idx   = r_lock_idx;
    end
`endif
  end

  assign w_take = i_load_en && w_found;
  assign w_nxt  = (w_idx == SEL_WIDTH'(NUM_IN - 1)) ? '0 : w_idx + 1'b1;
  assign o_idx  = w_idx;

  always_comb begin
    o_grant = '0;
    if (w_take) o_grant[w_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
`ifdef MUX_N_RR_LAST_EN
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
`endif
    end else if (w_take) begin
`ifdef MUX_N_RR_LAST_EN
      // Pointer only rotates at packet boundaries.
      if (i_last[w_idx]) begin
        r_lock <= 1'b0;
        r_ptr  <= w_nxt;
      end else begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_idx;
      end
`else
      r_ptr <= w_nxt;
`endif
    end
  end

endmodule

// File: rtl/mux_n_rr.sv
// mux_n_rr: NUM_IN-to-1 round-robin multiplexer with a one-deep
// registered output stage (valid/ready on both sides).
// Optional feature: define MUX_N_RR_LAST_EN for packet-lock mode
// (adds in_last / out_last; a channel keeps the grant until its last word).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : per-channel word valid
//   in_ready   : per-channel accept, one-hot or zero
//   in_data    : flat bus, channel i at [i*BUS_WIDTH +: BUS_WIDTH]
//   out_valid  : output register holds a word
//   out_ready  : downstream accept
//   out_data   : registered word
//   out_sel    : source channel of out_data
//   in_last / out_last : end-of-packet flags (MUX_N_RR_LAST_EN only)
module mux_n_rr
  import mux_n_rr_pkg::*;
#(
  parameter  int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter  int NUM_IN    = DEF_NUM_IN,
  localparam int SEL_WIDTH = sel_w(NUM_IN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  input  logic [NUM_IN*BUS_WIDTH-1:0] in_data,
`ifdef MUX_N_RR_LAST_EN
  input  logic [NUM_IN-1:0]           in_last,
  output logic                        out_last,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BUS_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]        out_sel
);

  logic [NUM_IN-1:0][BUS_WIDTH-1:0] w_ch;
  logic [NUM_IN-1:0]                w_grant;
  logic [SEL_WIDTH-1:0]             w_idx;
  logic                             w_load_en;
  logic                             w_take;

  logic                             r_valid;
  logic [BUS_WIDTH-1:0]             r_data;
  logic [SEL_WIDTH-1:0]             r_sel;
`ifdef MUX_N_RR_LAST_EN
  logic                             r_last;
`endif

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign w_ch[g] = in_data[g*BUS_WIDTH +: BUS_WIDTH];
  end

  // Reset gates load_en so no channel sees ready while reset is high.
  assign w_load_en = !reset && (!r_valid || out_ready);

  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (in_valid),
    .i_load_en (w_load_en),
`ifdef MUX_N_RR_LAST_EN
    .i_last    (in_last),
`endif
    .o_grant   (w_grant),
    .o_idx     (w_idx)
  );

  assign in_ready = w_grant;
  assign w_take   = |w_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
`ifdef MUX_N_RR_LAST_EN
      r_last  <= 1'b0;
`endif
    end else if (w_take) begin
      // Load covers both the empty case and consume-and-refill.
      r_valid <= 1'b1;
      r_data  <= w_ch[w_idx];
      r_sel   <= w_idx;
`ifdef MUX_N_RR_LAST_EN
      r_last  <= in_last[w_idx];
`endif
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
`ifdef MUX_N_RR_LAST_EN
  assign out_last  = r_last;
`endif

endmodule

// File: tb/tb_mux_n_rr.sv
module tb_mux_n_rr;

  localparam int BW = 16;
  localparam int NI = 4;

  logic          clk;
  logic          reset;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic [NI*BW-1:0] in_data;
  logic [NI-1:0] in_last;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [1:0]    out_sel;

  int checks   = 0;
  int failures = 0;

  mux_n_rr #(.BUS_WIDTH(BW), .NUM_IN(NI)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MUX_N_RR_LAST_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

`ifndef MUX_N_RR_LAST_EN
  assign out_last = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    bit       rst;
    bit [3:0] v;
    bit       ordy;
    bit [3:0] rdy;   // expected in_ready before the edge
    bit       ov;    // expected registers after the edge
    bit [1:0] sel;
    bit [15:0] dat;
  } vec_t;

  vec_t vecs[20];

  // reference model state
  int mv, md, ms, mptr;
  int d[NI];

  initial begin
    int k;
    int c;
    logic [NI-1:0] erdy;

    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    in_last   = '1;
    in_data   = {16'h0002, 16'h0003, 16'h000A, 16'h0005};

    // reset, idle after reset
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0};
    vecs[1]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0};
    // all valid, streaming: 0,1,2,3,0 no bubbles
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h5};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hA};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h3};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h2};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h5};
    // drain, then only ch2 valid with downstream stalled
    vecs[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h5};
    vecs[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 16'h3};
    vecs[10] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h3};
    vecs[11] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h3};
    vecs[12] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h3};
    vecs[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 16'h3};
    // ptr=3, ch1+ch3 valid -> 3 then 1
    vecs[14] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h2};
    vecs[15] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'hA};
    // hold, reset with word held, word discarded
    vecs[16] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 16'hA};
    vecs[17] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0};
    vecs[18] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0};
    // first grant after reset favours ch0
    vecs[19] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h5};

    for (int i = 0; i < 20; i++) begin
      reset     = vecs[i].rst;
      in_valid  = vecs[i].v;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].dat));
      if (vecs[i].ov)
        chk($sformatf("vec%0d_out_sel", i), 32'(out_sel), 32'(vecs[i].sel));
    end

    // randomized traffic against a behavioural model
    mv = 0; md = 0; ms = 0; mptr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset     = (cyc == 0) || ($urandom_range(0, 49) == 0);
      in_valid  = NI'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      for (int j = 0; j < NI; j++) begin
        d[j] = int'($urandom_range(0, 65535));
        in_data[j*BW +: BW] = BW'(d[j]);
      end
      // who should be granted: first valid channel at or after mptr
      k = -1;
      if (!reset && (mv == 0 || out_ready))
        for (int off = 0; off < NI; off++) begin
          c = (mptr + off) % NI;
          if (k < 0 && in_valid[c]) k = c;
        end
      erdy = '0;
      if (k >= 0) erdy[k] = 1'b1;
      #1;
      chk("rand_in_ready", 32'(in_ready), 32'(erdy));
      @(posedge clk); #1;
      if (reset) begin
        mv = 0; md = 0; ms = 0; mptr = 0;
      end else if (k >= 0) begin
        mv = 1; md = d[k]; ms = k; mptr = (k + 1) % NI;
      end else if (out_ready) begin
        mv = 0;
      end
      chk("rand_out_valid", 32'(out_valid), 32'(mv));
      chk("rand_out_data", 32'(out_data), 32'(md));
      chk("rand_out_sel", 32'(out_sel), 32'(ms));
    end

`ifdef MUX_N_RR_LAST_EN
    // packet lock: move ptr to 1, then ch0 sends 3-word packet while ch1 waits
    in_data   = {16'h0002, 16'h0003, 16'h000A, 16'h0005};
    reset = 1'b1; in_valid = '0; out_ready = 1'b1; in_last = '1;
    @(posedge clk); #1;
    chk("lock_reset_out_last", 32'(out_last), 32'd0);
    reset = 1'b0;
    in_valid = 4'b0001; in_last = 4'b0001;
    #1; chk("lock_pre_rdy", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("lock_pre_sel", 32'(out_sel), 32'd0);
    in_valid = 4'b0001; in_last = 4'b0000;
    #1; chk("lock_w1_rdy", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("lock_w1_sel", 32'(out_sel), 32'd0);
    chk("lock_w1_last", 32'(out_last), 32'd0);
    in_valid = 4'b0011; in_last = 4'b0000;
    #1; chk("lock_w2_rdy", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("lock_w2_sel", 32'(out_sel), 32'd0);
    in_valid = 4'b0011; in_last = 4'b0001;
    #1; chk("lock_w3_rdy", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    chk("lock_w3_sel", 32'(out_sel), 32'd0);
    chk("lock_w3_last", 32'(out_last), 32'd1);
    in_valid = 4'b0011; in_last = 4'b0011;
    #1; chk("lock_next_rdy", 32'(in_ready), 32'b0010);
    @(posedge clk); #1;
    chk("lock_next_sel", 32'(out_sel), 32'd1);
    chk("lock_next_data", 32'(out_data), 32'hA);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
